mem8x8_wr_ctrl: RTL and testbench
=================================

# mem8x8_wr_ctrl

Synchronous access controller sitting directly upstream of the 8x8 latch array. It accepts single-word read/write requests over a valid/ready handshake and drives each row's shared data bus and one-hot write-enable with guaranteed setup, strobe and hold phases so that the level-sensitive latches capture cleanly. Read data is taken from the selected row's Q outputs and returned with a one-cycle response strobe.

## Interface
- `ADDR_W`, 3: request address width.
- `DATA_W`, 8: word width, which is also the latch count per row.
- `ROWS`, 8: number of rows. Must satisfy ROWS ≤ 2^ADDR_W.
- `SETUP_CYC`, 1: cycles `row_data` is stable before `row_we` rises. Must be ≥1.
- `STROBE_CYC`, 2: cycles `row_we` is held high. Must be ≥1.
- `HOLD_CYC`, 1: cycles `row_data` is held after `row_we` falls. Must be ≥1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  controller idle and able to accept a request.
- `req_we`  in  1  1 = write, 0 = read.
- `req_addr`  in  ADDR_W  row select.
- `req_wdata`  in  DATA_W  write word.
- `rsp_valid`  out  1  one-cycle completion pulse, for both reads and writes.
- `rsp_rdata`  out  DATA_W  read word; valid while `rsp_valid` is high.
- `row_data`  out  DATA_W  shared data bus to all rows.
- `row_we`  out  ROWS  one-hot row write-enable.
- `row_q`  in  ROWS*DATA_W  latch Q outputs; row r occupies bits [r*DATA_W +: DATA_W].
- `wr_err`  out  1  write-verify mismatch pulse (see Configuration).

## Operation
- FSM states: IDLE, SETUP, STROBE, HOLD, READ, VERIFY (with macro only), RESP.
- IDLE: `req_ready`=1. On `req_valid && req_ready`, capture `req_we`, `req_addr` and `req_wdata`.
  - Write → SETUP. Read → READ.
- SETUP: `row_data` = captured word, `row_we` = 0. Lasts SETUP_CYC cycles, then → STROBE.
- STROBE: `row_we` = one-hot(addr), `row_data` held. Lasts STROBE_CYC cycles, then → HOLD.
- HOLD: `row_we` = 0, `row_data` held. Lasts HOLD_CYC cycles, then → VERIFY or RESP.
- READ: sample `row_q[addr]` into `rsp_rdata`, then → RESP.
- RESP: `rsp_valid` = 1 for exactly one cycle, then → IDLE.
- Phase length is set by one down-counter of width $clog2(max phase)+1, reloaded on each phase entry.
- `row_data` keeps its last driven value in IDLE, READ and RESP. It changes only on entry to SETUP.
- Write with addr ≥ ROWS: all phases run, `row_we` stays 0, `rsp_valid` is still given.
- Read with addr ≥ ROWS: `rsp_rdata` = 0.
- `rsp_rdata` keeps its value until the next read. It is not modified by writes.
- `req_*` inputs are ignored outside IDLE. There is no request queue.

## Timing
- Reset (asynchronous, immediate):
  - state = IDLE.
  - `row_we`=0 combinationally from `rst_n`, so there are no glitches into the latches.
  - `row_data`=0, `rsp_rdata`=0, `rsp_valid`=0, `wr_err`=0, `req_ready`=1 once released.
  - Latch contents are not touched.
- Write accepted at edge 0:
  - `row_data` is valid from cycle 1.
  - `row_we` is high in cycles SETUP_CYC+1 … SETUP_CYC+STROBE_CYC.
  - `rsp_valid` is high in cycle S+T+H+1 (+1 with the macro).
  - `req_ready` returns the following cycle.
  - Defaults: `rsp_valid` in cycle 5, next accept at edge 6.
- Read accepted at edge 0: READ in cycle 1, `rsp_valid` and `rsp_rdata` in cycle 2, `req_ready` in cycle 3.
- Reset asserted mid-STROBE: `row_we` drops in the same cycle and the response is discarded.
- Simultaneous events: `req_ready` is deasserted throughout every non-IDLE state, including RESP, so requests never overlap responses.

## Configuration
- `MEM8X8_WRITE_VERIFY_EN` defined:
  - VERIFY state after HOLD compares `row_q[addr]` with the captured word.
  - On mismatch, `wr_err` pulses for one cycle, coincident with `rsp_valid`.
  - Adds one cycle of write latency.
- Not defined: no VERIFY state, `wr_err` tied 0, write latency S+T+H+1.

## Structure
- Package `mem8x8_pkg` holds:
  - the state enum;
  - default ADDR_W, DATA_W, ROWS and phase-length constants;
  - a `row_slice` function for `row_q` indexing.
- Sub-module `mem8x8_row_dec`: address → ROWS one-hot decode, gated by the strobe enable, outputs 0 when addr ≥ ROWS. It is shared with the read-side mux select.

## Test plan
- Reset, then write addr 3, data 0xA5 → `row_we`=8'b0000_1000 in cycles 2–3 only, `row_data`=0xA5 in cycles 1–4, `rsp_valid` in cycle 5.
- Read addr 3 with a latch model behind the controller → `rsp_rdata`=0xA5 in cycle 2.
- `req_valid` held high back-to-back with write 0x3C@0 then read @0 → second accept at edge 6, read returns 0x3C, no overlapping `row_we`.
- Drop `rst_n` during STROBE → `row_we`=0 in the same cycle, no `rsp_valid`, `req_ready`=1 after release.
- With the macro defined, the latch model has row 5 bit 0 stuck at 0; write 0xFF@5 → `wr_err` and `rsp_valid` pulse together in cycle 6.
- ROWS=6, write addr 7 → `row_we` stays 0, `rsp_valid` still pulses. Read addr 7 → `rsp_rdata`=0.

Source files
------------

// File: rtl/mem8x8_pkg.sv
// Shared types and defaults for the 8x8 latch-array access controller.
package mem8x8_pkg;

  localparam int unsigned MEM_ADDR_W     = 3;
  localparam int unsigned MEM_DATA_W     = 8;
  localparam int unsigned MEM_ROWS       = 8;
  localparam int unsigned MEM_SETUP_CYC  = 1;
  localparam int unsigned MEM_STROBE_CYC = 2;
  localparam int unsigned MEM_HOLD_CYC   = 1;

  // Upper bounds for the generic row slicing helper.
  localparam int unsigned SLICE_MAX_W = 1024;
  localparam int unsigned WORD_MAX_W  = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETUP  = 3'd1,
    ST_STROBE = 3'd2,
    ST_HOLD   = 3'd3,
    ST_READ   = 3'd4,
    ST_VERIFY = 3'd5,
    ST_RESP   = 3'd6
  } state_e;

  // Extract row 'row' of a flattened Q bus; caller truncates to its word width.
  function automatic logic [WORD_MAX_W-1:0] row_slice(input logic [SLICE_MAX_W-1:0] q,
                                                      input int unsigned row,
                                                      input int unsigned width);
    logic [SLICE_MAX_W-1:0] sh;
    sh = q >> (row * width);
    return WORD_MAX_W'(sh);
  endfunction

endpackage

// File: rtl/mem8x8_row_dec.sv
// Address to one-hot row select; all zero when disabled or address out of range.
module mem8x8_row_dec #(
  parameter int unsigned ADDR_W = 3,
  parameter int unsigned ROWS   = 8
) (
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              en_i,
  output logic [ROWS-1:0]   onehot_o
);

  // Rows that do not exist never match, so addr >= ROWS decodes to zero.
  always_comb begin
    onehot_o = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (en_i && (addr_i == ADDR_W'(r))) onehot_o[r] = 1'b1;
    end
  end

endmodule

// File: rtl/mem8x8_wr_ctrl.sv
// Read/write controller for the 8x8 latch array with setup/strobe/hold phasing.
// Optional write-verify state enabled by defining MEM8X8_WRITE_VERIFY_EN.
module mem8x8_wr_ctrl
  import mem8x8_pkg::*;
#(
  parameter int unsigned ADDR_W     = MEM_ADDR_W,
  parameter int unsigned DATA_W     = MEM_DATA_W,
  parameter int unsigned ROWS       = MEM_ROWS,
  parameter int unsigned SETUP_CYC  = MEM_SETUP_CYC,
  parameter int unsigned STROBE_CYC = MEM_STROBE_CYC,
  parameter int unsigned HOLD_CYC   = MEM_HOLD_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [ADDR_W-1:0]      req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic [DATA_W-1:0]      row_data,
  output logic [ROWS-1:0]        row_we,
  input  logic [ROWS*DATA_W-1:0] row_q,
  output logic                   wr_err
);

  localparam int unsigned MAX_PH = (SETUP_CYC > STROBE_CYC)
                                   ? ((SETUP_CYC > HOLD_CYC) ? SETUP_CYC : HOLD_CYC)
                                   : ((STROBE_CYC > HOLD_CYC) ? STROBE_CYC : HOLD_CYC);
  localparam int unsigned CNT_W  = $clog2(MAX_PH) + 1;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   row_data_q, row_data_d;
  logic [ROWS-1:0]     row_we_q, row_we_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                req_ready_q, req_ready_d;
`ifdef MEM8X8_WRITE_VERIFY_EN
  logic                wr_err_q, wr_err_d;
`endif

  logic [ROWS-1:0]     sel_c;
  logic [DATA_W-1:0]   rd_mux_c;

  // Row select shared by the write strobe and the read/verify mux.
  mem8x8_row_dec #(
    .ADDR_W (ADDR_W),
    .ROWS   (ROWS)
  ) u_row_dec (
    .addr_i   (addr_q),
    .en_i     (state_q != ST_IDLE),
    .onehot_o (sel_c)
  );

  // Selected row's Q word, zero when no row is selected.
  always_comb begin
    rd_mux_c = '0;
    for (int unsigned r = 0; r < ROWS; r++) begin
      if (sel_c[r]) rd_mux_c = rd_mux_c | DATA_W'(row_slice(SLICE_MAX_W'(row_q), r, DATA_W));
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    row_data_d  = row_data_q;
    row_we_d    = row_we_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    req_ready_d = req_ready_q;
`ifdef MEM8X8_WRITE_VERIFY_EN
    wr_err_d    = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          addr_d      = req_addr;
          req_ready_d = 1'b0;
          if (req_we) begin
            row_data_d = req_wdata;
            cnt_d      = CNT_W'(SETUP_CYC - 1);
            state_d    = ST_SETUP;
          end else begin
            state_d = ST_READ;
          end
        end
      end
      ST_SETUP: begin
        if (cnt_q == '0) begin
          row_we_d = sel_c;
          cnt_d    = CNT_W'(STROBE_CYC - 1);
          state_d  = ST_STROBE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_STROBE: begin
        if (cnt_q == '0) begin
          row_we_d = '0;
          cnt_d    = CNT_W'(HOLD_CYC - 1);
          state_d  = ST_HOLD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
`ifdef MEM8X8_WRITE_VERIFY_EN
          state_d = ST_VERIFY;
`else
          rsp_valid_d = 1'b1;
          state_d     = ST_RESP;
`endif
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
`ifdef MEM8X8_WRITE_VERIFY_EN
      ST_VERIFY: begin
        // Out-of-range writes touch no latch, so there is nothing to verify.
        wr_err_d    = (|sel_c) && (rd_mux_c != row_data_q);
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
`endif
      ST_READ: begin
        rsp_rdata_d = rd_mux_c;
        rsp_valid_d = 1'b1;
        state_d     = ST_RESP;
      end
      ST_RESP: begin
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
      default: begin
        row_we_d    = '0;
        req_ready_d = 1'b1;
        state_d     = ST_IDLE;
      end
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      row_data_q  <= '0;
      row_we_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      req_ready_q <= 1'b1;
`ifdef MEM8X8_WRITE_VERIFY_EN
      wr_err_q    <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      row_data_q  <= row_data_d;
      row_we_q    <= row_we_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      req_ready_q <= req_ready_d;
`ifdef MEM8X8_WRITE_VERIFY_EN
      wr_err_q    <= wr_err_d;
`endif
    end
  end

  // Write enables are also gated directly by rst_n so the latches never see a glitch.
  assign row_we    = row_we_q & {ROWS{rst_n}};
  assign row_data  = row_data_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign req_ready = req_ready_q;
`ifdef MEM8X8_WRITE_VERIFY_EN
  assign wr_err    = wr_err_q;
`else
  assign wr_err    = 1'b0;
`endif

endmodule

// File: tb/tb_mem8x8_wr_ctrl.sv
// Scoreboard bench for mem8x8_wr_ctrl with a latch-array model behind it.
module tb_mem8x8_wr_ctrl;

  localparam int unsigned TB_ROWS = 6;
  localparam int unsigned DW      = 8;
  localparam int unsigned AW      = 3;
`ifdef MEM8X8_WRITE_VERIFY_EN
  localparam int unsigned VERIFY  = 1;
`else
  localparam int unsigned VERIFY  = 0;
`endif
  localparam int unsigned RSP_CYC = 5 + VERIFY;

  logic                   clk;
  logic                   rst_n;
  logic                   req_valid;
  logic                   req_ready;
  logic                   req_we;
  logic [AW-1:0]          req_addr;
  logic [DW-1:0]          req_wdata;
  logic                   rsp_valid;
  logic [DW-1:0]          rsp_rdata;
  logic [DW-1:0]          row_data;
  logic [TB_ROWS-1:0]     row_we;
  logic [TB_ROWS*DW-1:0]  row_q;
  logic                   wr_err;

  mem8x8_wr_ctrl #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .ROWS       (TB_ROWS),
    .SETUP_CYC  (1),
    .STROBE_CYC (2),
    .HOLD_CYC   (1)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .row_data  (row_data),
    .row_we    (row_we),
    .row_q     (row_q),
    .wr_err    (wr_err)
  );

  always #5 clk = ~clk;

  // Level-sensitive latch array; row 5 bit 0 stuck at 0 when verify is built in.
  logic [DW-1:0] lat [TB_ROWS];
  always @(row_we or row_data) begin
    for (int r = 0; r < int'(TB_ROWS); r++) if (row_we[r]) lat[r] = row_data;
  end
  always_comb begin
    for (int r = 0; r < int'(TB_ROWS); r++) row_q[r*DW +: DW] = lat[r];
`ifdef MEM8X8_WRITE_VERIFY_EN
    row_q[5*DW] = 1'b0;
`endif
  end

  typedef struct {
    logic          is_wr;
    logic [DW-1:0] rdata;
    logic          err;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] ref_mem [TB_ROWS];
  logic [DW-1:0] last_rd;
  int            errs;
  int            checks;
  int            rsp_cnt;
  int            req_cnt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
    logic [DW-1:0] r;
    if (int'(a) >= int'(TB_ROWS)) return '0;
    r = ref_mem[a];
    if (VERIFY == 1 && a == AW'(5)) r[0] = 1'b0;
    return r;
  endfunction

  // Model the effect of a request and queue the response it should produce.
  task automatic push_exp(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    exp_t e;
    req_cnt++;
    if (we) begin
      if (int'(a) < int'(TB_ROWS)) ref_mem[a] = d;
      e.is_wr = 1'b1;
      e.rdata = last_rd;
      e.err   = (VERIFY == 1) && (int'(a) < int'(TB_ROWS)) && (exp_rd(a) != d);
    end else begin
      last_rd = exp_rd(a);
      e.is_wr = 1'b0;
      e.rdata = last_rd;
      e.err   = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Response monitor and one-hot write-enable check.
  always @(negedge clk) begin
    if (rst_n) begin
      if (row_we != '0) check_eq("we_onehot", 32'($countones(row_we)), 32'd1);
      if (rsp_valid) begin
        rsp_cnt++;
        if (sb.size() == 0) begin
          check_eq("rsp_unexpected", 32'(sb.size()), 32'd1);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_eq(e.is_wr ? "wr_rdata_hold" : "rd_data", 32'(rsp_rdata), 32'(e.rdata));
          check_eq("wr_err", 32'(wr_err), 32'(e.err));
        end
      end else if (wr_err) begin
        check_eq("wr_err_stray", 32'(wr_err), 32'd0);
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) check_eq("ready_timeout", 32'(req_ready), 32'd1);
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
  endtask

  // Write with cycle-exact phase checks relative to the accept edge.
  task automatic timed_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    logic [TB_ROWS-1:0] ew;
    wait_ready();
    drive(1'b1, a, d);
    push_exp(1'b1, a, d);
    @(posedge clk);
    for (int k = 1; k <= int'(RSP_CYC) + 1; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      ew = (int'(a) < int'(TB_ROWS) && k >= 2 && k <= 3) ? (TB_ROWS'(1) << a) : '0;
      check_eq("wr_we", 32'(row_we), 32'(ew));
      check_eq("wr_data", 32'(row_data), 32'(d));
      check_eq("wr_rsp", 32'(rsp_valid), 32'(k == int'(RSP_CYC)));
      check_eq("wr_ready", 32'(req_ready), 32'(k == int'(RSP_CYC) + 1));
    end
  endtask

  task automatic timed_read(input logic [AW-1:0] a);
    wait_ready();
    drive(1'b0, a, 8'h00);
    push_exp(1'b0, a, 8'h00);
    @(posedge clk);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 1'b0;
      check_eq("rd_rsp", 32'(rsp_valid), 32'(k == 2));
      check_eq("rd_ready", 32'(req_ready), 32'(k == 3));
      check_eq("rd_we", 32'(row_we), 32'd0);
    end
  endtask

  task automatic run_req(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    wait_ready();
    drive(we, a, d);
    push_exp(we, a, d);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  initial begin
    int k;
    int saved;
    clk = 1'b0; rst_n = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    errs = 0; checks = 0; rsp_cnt = 0; req_cnt = 0; last_rd = '0;
    for (int r = 0; r < int'(TB_ROWS); r++) begin
      lat[r] = '0;
      ref_mem[r] = '0;
    end

    // Reset values
    repeat (3) @(negedge clk);
    check_eq("rst_we", 32'(row_we), 32'd0);
    check_eq("rst_data", 32'(row_data), 32'd0);
    check_eq("rst_rsp", 32'(rsp_valid), 32'd0);
    check_eq("rst_rdata", 32'(rsp_rdata), 32'd0);
    check_eq("rst_err", 32'(wr_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_ready", 32'(req_ready), 32'd1);

    // Basic write then read back
    timed_write(3'd3, 8'hA5);
    timed_read(3'd3);

    // Back-to-back with req_valid held high
    wait_ready();
    drive(1'b1, 3'd0, 8'h3C);
    push_exp(1'b1, 3'd0, 8'h3C);
    @(posedge clk);
    @(negedge clk);
    drive(1'b0, 3'd0, 8'h00);
    k = 1;
    while (!req_ready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_eq("b2b_accept_edge", 32'(k), 32'(RSP_CYC + 1));
    push_exp(1'b0, 3'd0, 8'h00);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;

    // Reset during STROBE discards the write response
    wait_ready();
    saved = rsp_cnt;
    drive(1'b1, 3'd1, 8'h11);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check_eq("strobe_we", 32'(row_we), 32'h2);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rst_mid_we", 32'(row_we), 32'd0);
    check_eq("rst_mid_rsp", 32'(rsp_valid), 32'd0);
    ref_mem[1] = 8'h11;
    last_rd = '0;
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check_eq("rst_rel_ready", 32'(req_ready), 32'd1);
    check_eq("rst_rel_rdata", 32'(rsp_rdata), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("rst_no_rsp", 32'(rsp_cnt), 32'(saved));

    // Out-of-range address
    timed_write(3'd7, 8'h5A);
    timed_read(3'd7);
    timed_read(3'd3);

    // Row 5 (stuck bit when verify is built in)
    timed_write(3'd5, 8'hFF);
    timed_read(3'd5);

    // Random mix through the scoreboard
    for (int i = 0; i < 12; i++) begin
      run_req(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom_range(0, 255)));
    end
    wait_ready();

    k = 0;
    while (sb.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    check_eq("sb_drained", 32'(sb.size()), 32'd0);
    check_eq("rsp_count", 32'(rsp_cnt), 32'(req_cnt));

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
